// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Packet-granular round-robin arbiter sharing one UART transmit byte stream
//   between NUM_REQ requesters. A grant is held until the requester's last
//   byte, but is force-released after MAX_BURST bytes or after IDLE_TIMEOUT
//   consecutive cycles of the granted requester's valid being low. The data
//   path is combinational pass-through; the block stores no data bytes.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester byte valid
//   req_data_i   per-requester byte, requester k on bits [8k+7:8k]
//   req_last_i   per-requester end-of-packet marker
//   req_ready_o  per-requester accept (only the granted bit can be high)
//   tx_valid_o   byte valid toward the tx FIFO
//   tx_data_o    byte toward the tx FIFO
//   tx_ready_i   tx FIFO not full
//   grant_o      one-hot current grant, zero when idle
//   busy_o       a grant is held
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam int ICNT_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ICNT_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic                g_valid;
  logic                g_last;
  logic                xfer;
  logic                release_now;

  // Round-robin pick: scan upward from the requester after the last grant,
  // so the most recently served requester is considered last.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_REQ;
      if (!sel_found && req_valid_i[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(idx);
      end
    end
  end

  assign g_valid = req_valid_i[grant_q];
  assign g_last  = req_last_i[grant_q];
  assign xfer    = (state_q == ACTIVE) && g_valid && tx_ready_i;

  // Any of the three release causes ends the grant; backpressure with valid
  // high never reaches the timeout because idle only counts valid-low cycles.
  assign release_now = (state_q == ACTIVE) &&
                       ((xfer && (g_last || (byte_cnt_q == BCNT_W'(MAX_BURST - 1)))) ||
                        (!g_valid && (idle_cnt_q == ICNT_W'(IDLE_TIMEOUT - 1))));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = ACTIVE;
          grant_d    = sel_idx;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (release_now) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          byte_cnt_d   = '0;
          idle_cnt_d   = '0;
        end else begin
          if (xfer) begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
          if (g_valid) begin
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + ICNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: quiescent in IDLE, pass-through of the granted lane in ACTIVE
  always_comb begin
    req_ready_o = '0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    grant_o     = '0;
    busy_o      = 1'b0;
    if (state_q == ACTIVE) begin
      tx_valid_o           = g_valid;
      tx_data_o            = req_data_i[8*int'(grant_q) +: 8];
      req_ready_o[grant_q] = tx_ready_i;
      grant_o[grant_q]     = 1'b1;
      busy_o               = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int IT = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
    .tx_ready_i(tx_ready), .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Per-requester packet streams: {last, data}
  logic [8:0] pq [N][$];

  typedef struct {int cyc; int g; logic [7:0] d;} ent_t;
  ent_t lg[$];

  // Behavioural model of the grant
  bit m_busy;
  int m_g, m_last, m_bytes, m_idle;

  int cyc;
  int n_checks;
  int n_fail;
  int t0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (pq[k].size() > 0) begin
        req_valid[k]        = 1'b1;
        req_data[8*k +: 8]  = pq[k][0][7:0];
        req_last[k]         = pq[k][0][8];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[8*k +: 8]  = 8'h00;
        req_last[k]         = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_g     = 0;
    m_last  = N - 1;
    m_bytes = 0;
    m_idle  = 0;
  endtask

  // One clock: compare at the falling edge, advance model and stimulus after the rising edge.
  task automatic cycle();
    logic [N-1:0] pop;
    bit nbusy, done, v;
    int ng, nl, nbyt, nid, c;
    @(negedge clk);
    if (m_busy) begin
      check("tx_valid", tx_valid, req_valid[m_g]);
      check("tx_data", tx_data, req_data[8*m_g +: 8]);
      check("req_ready", req_ready, tx_ready ? (N'(1) << m_g) : '0);
      check("grant", grant, N'(1) << m_g);
      check("busy", busy, 1);
    end else begin
      check("tx_valid_idle", tx_valid, 0);
      check("tx_data_idle", tx_data, 0);
      check("req_ready_idle", req_ready, 0);
      check("grant_idle", grant, 0);
      check("busy_idle", busy, 0);
    end
    pop = req_valid & req_ready;
    if (tx_valid && tx_ready) lg.push_back('{cyc, oh2i(grant), tx_data});

    nbusy = m_busy; ng = m_g; nl = m_last; nbyt = m_bytes; nid = m_idle;
    if (!rst_n) begin
      nbusy = 1'b0; nl = N - 1; nbyt = 0; nid = 0;
    end else if (!m_busy) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (!nbusy && req_valid[c]) begin
          nbusy = 1'b1; ng = c; nbyt = 0; nid = 0;
        end
      end
    end else begin
      v = req_valid[m_g];
      done = 1'b0;
      if (v && tx_ready) begin
        nbyt = m_bytes + 1;
        if (req_last[m_g] || nbyt == MB) done = 1'b1;
      end
      if (v) nid = 0;
      else begin
        nid = m_idle + 1;
        if (nid == IT) done = 1'b1;
      end
      if (done) begin
        nbusy = 1'b0; nl = m_g; nbyt = 0; nid = 0;
      end
    end

    @(posedge clk);
    #1;
    m_busy = nbusy; m_g = ng; m_last = nl; m_bytes = nbyt; m_idle = nid;
    for (int k = 0; k < N; k++) if (pop[k] && pq[k].size() > 0) void'(pq[k].pop_front());
    cyc++;
    drive();
  endtask

  task automatic run(input int budget);
    int n;
    bit pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      cycle();
      n++;
      pending = m_busy;
      for (int k = 0; k < N; k++) if (pq[k].size() > 0) pending = 1'b1;
    end
    check("drain_budget", {31'd0, pending}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) pq[k].delete();
    tx_ready = 1'b1;
    drive();
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    lg.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; tx_ready = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    model_reset();
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_req_ready", req_ready, 0);

    // Two requesters, 3-byte packets each
    pq[0].push_back({1'b0, 8'hA0}); pq[0].push_back({1'b0, 8'hA1}); pq[0].push_back({1'b1, 8'hA2});
    pq[2].push_back({1'b0, 8'hC0}); pq[2].push_back({1'b0, 8'hC1}); pq[2].push_back({1'b1, 8'hC2});
    drive();
    t0 = cyc;
    cycle();
    check("s1_grant0", grant, 4'b0001);
    run(50);
    check("s1_count", lg.size(), 6);
    check("s1_a0_cyc", lg[0].cyc, t0 + 1);
    check("s1_a0", lg[0].d, 8'hA0);
    check("s1_a2_cyc", lg[2].cyc, t0 + 3);
    check("s1_a2", lg[2].d, 8'hA2);
    check("s1_c0_g", lg[3].g, 2);
    check("s1_c0_cyc", lg[3].cyc, t0 + 5);
    check("s1_c2", lg[5].d, 8'hC2);

    // All four valid with 1-byte packets, two rounds
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) pq[k].push_back({1'b1, 8'(8'h10 + k)});
    drive();
    run(50);
    check("s2_count", lg.size(), 8);
    for (int i = 0; i < 8; i++) check("s2_order", lg[i].g, i % 4);
    for (int i = 1; i < 8; i++) check("s2_spacing", lg[i].cyc - lg[i-1].cyc, 2);

    // Burst limit: req 1 sends 40 bytes while req 3 has a packet
    do_reset();
    for (int i = 1; i <= 40; i++) pq[1].push_back({(i == 40) ? 1'b1 : 1'b0, 8'(i)});
    pq[3].push_back({1'b0, 8'hD0}); pq[3].push_back({1'b0, 8'hD1}); pq[3].push_back({1'b1, 8'hD2});
    drive();
    run(200);
    check("s3_count", lg.size(), 43);
    check("s3_b16", lg[15].d, 8'd16);
    check("s3_b16_g", lg[15].g, 1);
    check("s3_d0_g", lg[16].g, 3);
    check("s3_d0", lg[16].d, 8'hD0);
    check("s3_d0_gap", lg[16].cyc - lg[15].cyc, 2);
    check("s3_b17_g", lg[19].g, 1);
    check("s3_b17", lg[19].d, 8'd17);
    check("s3_b33", lg[35].d, 8'd33);
    check("s3_b33_gap", lg[35].cyc - lg[34].cyc, 2);

    // Idle timeout: req 0 stalls after two bytes while req 1 waits
    do_reset();
    pq[0].push_back({1'b0, 8'hB0}); pq[0].push_back({1'b0, 8'hB1});
    pq[1].push_back({1'b1, 8'hE0});
    drive();
    run(100);
    check("s4_count", lg.size(), 3);
    check("s4_e0_g", lg[2].g, 1);
    check("s4_e0", lg[2].d, 8'hE0);
    check("s4_timeout_gap", lg[2].cyc - lg[1].cyc, 10);

    // Backpressure with valid high never times out
    do_reset();
    pq[0].push_back({1'b1, 8'hF0});
    tx_ready = 1'b0;
    drive();
    repeat (21) cycle();
    check("s4b_busy", busy, 1);
    check("s4b_grant", grant, 4'b0001);
    check("s4b_none", lg.size(), 0);
    tx_ready = 1'b1;
    run(20);
    check("s4b_count", lg.size(), 1);
    check("s4b_f0", lg[0].d, 8'hF0);

    // tx_ready toggling mid-packet
    do_reset();
    pq[2].push_back({1'b0, 8'h30}); pq[2].push_back({1'b0, 8'h31}); pq[2].push_back({1'b1, 8'h32});
    drive();
    cycle();
    tx_ready = 1'b1; cycle();
    tx_ready = 1'b0; #1;
    check("s5_ready_low", req_ready, 0);
    check("s5_hold_data", tx_data, 8'h31);
    check("s5_hold_valid", tx_valid, 1);
    cycle();
    tx_ready = 1'b0; cycle();
    tx_ready = 1'b1; cycle();
    tx_ready = 1'b1; cycle();
    run(20);
    check("s5_count", lg.size(), 3);
    check("s5_gap1", lg[1].cyc - lg[0].cyc, 3);
    check("s5_gap2", lg[2].cyc - lg[1].cyc, 1);
    check("s5_b1", lg[1].d, 8'h31);

    // Reset pulse mid-packet of req 2
    do_reset();
    for (int i = 0; i < 5; i++) pq[2].push_back({(i == 4) ? 1'b1 : 1'b0, 8'(8'h50 + i)});
    drive();
    cycle();
    cycle();
    check("s6_pre_valid", tx_valid, 1);
    check("s6_pre_grant", grant, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("s6_rst_valid", tx_valid, 0);
    check("s6_rst_grant", grant, 0);
    check("s6_rst_busy", busy, 0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    lg.delete();
    pq[3].push_back({1'b1, 8'h60});
    drive();
    run(50);
    check("s6_count", lg.size(), 5);
    check("s6_first_g", lg[0].g, 2);
    check("s6_resume", lg[0].d, 8'h51);
    check("s6_req3_g", lg[4].g, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
